// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and defaults for the two-requester
// round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam int DEFAULT_SIZE      = 4;
    localparam int DEFAULT_MAX_BURST = 4;

    function automatic arb_state_t other_side(input arb_state_t s);
        return (s == GRANT_A) ? GRANT_B : GRANT_A;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2to1_nbits.sv
// mux2to1_nbits: plain SIZE-bit 2:1 multiplexer, sel=1 picks a.
// Shared datapath owned by whichever requester holds the grant.
module mux2to1_nbits #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            sel,
    output logic [SIZE-1:0] y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin owner of a shared 2:1 mux with a
// one-entry output register. Burst cap built when MUX_ARB_BURST_LIMIT_EN.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SIZE      = DEFAULT_SIZE,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [SIZE-1:0] a_data,
    input  logic            a_last,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [SIZE-1:0] b_data,
    input  logic            b_last,
    output logic            b_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    input  logic            out_ready,
    output logic            sel,
    output logic            busy
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST out of range 1..255");
    end

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic            r_last_a;
    logic            w_last_a_nxt;
    logic            r_out_valid;
    logic [SIZE-1:0] r_out_data;
    logic [SIZE-1:0] w_mux;
    logic            w_space;
    logic            w_xfer;
    logic            w_last_beat;
    logic            w_other_valid;
    logic            w_limit;
    logic            w_release;

    assign sel       = (r_state == GRANT_A);
    assign busy      = (r_state != IDLE);
    assign w_space   = !r_out_valid || out_ready;
    assign a_ready   = (r_state == GRANT_A) && w_space;
    assign b_ready   = (r_state == GRANT_B) && w_space;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    assign w_xfer        = (a_valid && a_ready) || (b_valid && b_ready);
    assign w_last_beat   = sel ? a_last : b_last;
    assign w_other_valid = sel ? b_valid : a_valid;

    mux2to1_nbits #(.SIZE(SIZE)) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (sel),
        .y   (w_mux)
    );

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_limit   = w_xfer && (w_cnt_inc == CW'(MAX_BURST));

    // Beat counter: cleared whenever a grant is (re)entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE || w_release) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    assign w_limit = 1'b0;
`endif

    assign w_release = w_xfer && (w_last_beat || w_limit);

    // Next grant: round-robin in IDLE, handoff or hold on release.
    // A beat flagged last closes that side's burst, so its still-high
    // valid is the beat itself and is not a reason to re-grant it.
    always_comb begin
        w_state_nxt  = r_state;
        w_last_a_nxt = r_last_a;
        unique case (r_state)
            IDLE: begin
                if (a_valid && (!b_valid || !r_last_a)) begin
                    w_state_nxt = GRANT_A;
                end else if (b_valid) begin
                    w_state_nxt = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (w_release) begin
                    if (w_other_valid) begin
                        w_state_nxt = other_side(r_state);
                    end else if (w_last_beat) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == GRANT_A) begin
            w_last_a_nxt = 1'b1;
        end else if (w_state_nxt == GRANT_B) begin
            w_last_a_nxt = 1'b0;
        end
    end

    // Grant state and priority pointer; B counts as last after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last_a <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_a <= w_last_a_nxt;
        end
    end

    // One-entry output stage: load on transfer, drain on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed test-plan scenarios plus random traffic,
// checked against a behavioural model and a beat scoreboard.
module tb_mux2_rr_arbiter;

    localparam int SIZE      = 4;
    localparam int MAX_BURST = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            a_valid, a_last, a_ready;
    logic            b_valid, b_last, b_ready;
    logic [SIZE-1:0] a_data, b_data, out_data;
    logic            out_valid, out_ready, sel, busy;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // owner: 0 none, 1 A, 2 B; prev: side granted most recently
    int              m_owner, m_prev, m_beats;
    bit              m_ov;
    logic [SIZE-1:0] m_od;
    logic [SIZE-1:0] sb[$];
    bit              g_xa, g_xb;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic step();
        bit space, er_a, er_b, xa, xb, lb, lim, oth_v;
        int oth;
        #1;
        space = !m_ov || out_ready;
        er_a  = (m_owner == 1) && space;
        er_b  = (m_owner == 2) && space;
        chk("a_ready", a_ready, er_a);
        chk("b_ready", b_ready, er_b);
        chk("sel", sel, m_owner == 1);
        chk("busy", busy, m_owner != 0);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        xa = a_valid && er_a;
        xb = b_valid && er_b;
        g_xa = xa;
        g_xb = xb;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_extra", 1, 0);
                else chk("sb_data", out_data, sb.pop_front());
            end
            if (xa) sb.push_back(a_data);
            if (xb) sb.push_back(b_data);
        end
        if (reset) begin
            m_owner = 0; m_prev = 2; m_beats = 0; m_ov = 0; m_od = '0;
        end else begin
            if (xa || xb) begin
                m_od = xa ? a_data : b_data;
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (m_owner == 0) begin
                if (a_valid && b_valid) m_owner = (m_prev == 1) ? 2 : 1;
                else if (a_valid) m_owner = 1;
                else if (b_valid) m_owner = 2;
                if (m_owner != 0) begin
                    m_prev = m_owner;
                    m_beats = 0;
                end
            end else if (xa || xb) begin
                m_beats++;
                lb  = xa ? a_last : b_last;
                lim = 0;
`ifdef MUX_ARB_BURST_LIMIT_EN
                lim = (m_beats == MAX_BURST);
`endif
                if (lb || lim) begin
                    oth   = 3 - m_owner;
                    oth_v = (oth == 1) ? a_valid : b_valid;
                    if (oth_v) m_owner = oth;
                    else if (lb) m_owner = 0;
                    if (m_owner != 0) m_prev = m_owner;
                    m_beats = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_last = 0; a_data = '0;
        b_valid = 0; b_last = 0; b_data = '0;
        out_ready = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, bidx, a_before_b;
        bit b_done;
        logic [SIZE-1:0] seq[4];
        m_owner = 0; m_prev = 2; m_beats = 0; m_ov = 0; m_od = '0;
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);

        // tie with single-beat bursts alternates A,B,A,B
        seq[0] = 4'h3; seq[1] = 4'hC; seq[2] = 4'h3; seq[3] = 4'hC;
        a_valid = 1; b_valid = 1; a_last = 1; b_last = 1;
        a_data = 4'h3; b_data = 4'hC;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k >= 1) chk("tie_seq", out_data, seq[k-1]);
        end
        idle_inputs();
        repeat (3) step();

        // A-only burst 1,2,3
        idx = 0;
        for (int t = 0; t < 20 && idx < 3; t++) begin
            a_valid = 1; a_data = SIZE'(idx + 1); a_last = (idx == 2);
            step();
            if (g_xa) idx++;
        end
        chk("a_burst_cnt", idx, 3);
        chk("a_burst_idle", busy, 0);
        idle_inputs();
        repeat (3) step();

        // A streams 6 beats, B waiting: handoff point depends on limit
        idx = 0; bidx = 0; b_done = 0; a_before_b = -1;
        for (int t = 0; t < 40 && (idx < 6 || !b_done); t++) begin
            a_valid = (idx < 6); a_data = SIZE'(idx + 1); a_last = (idx == 5);
            b_valid = (t > 0) && !b_done; b_data = 4'hE; b_last = 1;
            step();
            if (g_xb && !b_done) begin
                b_done = 1;
                a_before_b = idx;
            end
            if (g_xa) idx++;
        end
        chk("stream_a_cnt", idx, 6);
`ifdef MUX_ARB_BURST_LIMIT_EN
        chk("handoff_at", a_before_b, MAX_BURST);
`else
        chk("handoff_at", a_before_b, 6);
`endif
        idle_inputs();
        repeat (3) step();

        // sink stall mid-burst
        idx = 0;
        for (int t = 0; t < 30 && idx < 5; t++) begin
            a_valid = 1; a_data = SIZE'(idx + 8); a_last = (idx == 4);
            out_ready = !(t >= 3 && t < 6);
            step();
            if (g_xa) idx++;
        end
        chk("stall_cnt", idx, 5);
        idle_inputs();
        repeat (3) step();
        chk("stall_drained", sb.size(), 0);

        // reset during 2nd beat of a B burst
        idx = 0;
        for (int t = 0; t < 20 && idx < 1; t++) begin
            b_valid = 1; b_data = 4'h5; b_last = 0;
            step();
            if (g_xb) idx++;
        end
        b_data = 4'h6;
        reset = 1;
        step();
        reset = 0;
        b_valid = 0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_busy", busy, 0);
        a_valid = 1; b_valid = 1; a_last = 1; b_last = 1;
        step();
        chk("post_rst_tie_a", sel, 1);
        idle_inputs();
        repeat (3) step();

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            reset     = ($urandom_range(0, 299) == 0);
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            a_last    = ($urandom_range(0, 2) == 0);
            b_last    = ($urandom_range(0, 2) == 0);
            a_data    = SIZE'($urandom);
            b_data    = SIZE'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 0;
        idle_inputs();
        repeat (4) step();
        chk("final_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
